// File: rtl/pipelined_adder_tree.sv
// Fully pipelined binary adder tree. Sums NUM_IN unsigned DW_DATA-bit lanes
// modulo 2^DW_DATA, accepting one vector per clock with one register per level.
module pipelined_adder_tree #(
  parameter int unsigned DW_DATA = 8,
  parameter int unsigned NUM_IN  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN*DW_DATA-1:0]   in,
  output logic [DW_DATA-1:0]          out
);

  // Lane count is zero-padded to a power of two so every leaf sits at the same
  // depth and every root-to-leaf path crosses exactly LEVELS registers.
  localparam int unsigned LEVELS = $clog2(NUM_IN);
  localparam int unsigned PADN   = 32'(1) << LEVELS;

  if (NUM_IN == 1) begin : g_single
    logic [DW_DATA-1:0] out_q;

    // Single lane: register it once so the latency never drops below one.
    always_ff @(posedge clk) begin
      if (rst) out_q <= '0;
      else     out_q <= in;
    end

    assign out = out_q;
  end else begin : g_tree
    // Heap-ordered tree: node i has children 2i and 2i+1; node 1 is the root.
    // Children with index >= PADN are leaves, i.e. padded input lanes.
    logic [DW_DATA-1:0] leaf   [PADN];
    logic [DW_DATA-1:0] node_q [1:PADN-1];

    for (genvar k = 0; k < PADN; k++) begin : g_leaf
      if (k < NUM_IN) begin : g_lane
        assign leaf[k] = in[k*DW_DATA +: DW_DATA];
      end else begin : g_pad
        assign leaf[k] = '0;
      end
    end

    for (genvar i = 1; i < PADN; i++) begin : g_node
      if (2 * i >= PADN) begin : g_bottom
        // First level: add a pair of input lanes.
        always_ff @(posedge clk) begin
          if (rst) node_q[i] <= '0;
          else     node_q[i] <= leaf[2*i-PADN] + leaf[2*i+1-PADN];
        end
      end else begin : g_inner
        // Upper levels: add the two registered child sums.
        always_ff @(posedge clk) begin
          if (rst) node_q[i] <= '0;
          else     node_q[i] <= node_q[2*i] + node_q[2*i+1];
        end
      end
    end

    assign out = node_q[1];
  end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed and table-driven checks of pipelined_adder_tree at the default size,
// plus a random sweep over a few other lane counts and widths.
module tb_pipelined_adder_tree;

  logic clk;
  logic rst;

  // Default configuration: 8 lanes of 8 bits, latency 3.
  logic [63:0]  in0;
  logic [7:0]   out0;
  // Sweep configurations: (NUM_IN, DW_DATA, latency)
  logic [7:0]   in_a;  logic [7:0]  out_a;   // (1, 8, 1)
  logic [11:0]  in_b;  logic [3:0]  out_b;   // (3, 4, 2)
  logic [79:0]  in_c;  logic [15:0] out_c;   // (5, 16, 3)
  logic [127:0] in_d;  logic [7:0]  out_d;   // (16, 8, 4)

  int vectors    = 0;
  int miscompares = 0;

  pipelined_adder_tree #(.DW_DATA(8),  .NUM_IN(8))  dut0 (.clk(clk), .rst(rst), .in(in0),  .out(out0));
  pipelined_adder_tree #(.DW_DATA(8),  .NUM_IN(1))  dut_a (.clk(clk), .rst(rst), .in(in_a), .out(out_a));
  pipelined_adder_tree #(.DW_DATA(4),  .NUM_IN(3))  dut_b (.clk(clk), .rst(rst), .in(in_b), .out(out_b));
  pipelined_adder_tree #(.DW_DATA(16), .NUM_IN(5))  dut_c (.clk(clk), .rst(rst), .in(in_c), .out(out_c));
  pipelined_adder_tree #(.DW_DATA(8),  .NUM_IN(16)) dut_d (.clk(clk), .rst(rst), .in(in_d), .out(out_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain lane-by-lane sum, reduced modulo 2^w.
  function automatic logic [31:0] ref_sum(input logic [127:0] v, input int n, input int w);
    logic [31:0]  acc;
    logic [127:0] mask;
    acc  = '0;
    mask = (128'(1) << w) - 128'(1);
    for (int k = 0; k < n; k++) acc = acc + 32'((v >> (k * w)) & mask);
    return acc & ((32'(1) << w) - 32'(1));
  endfunction

  // Latency model for the sweep instances: a delay line of reference sums.
  logic [15:0] pipe [4][4];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 4; s++)
        for (int k = 0; k < 4; k++) pipe[s][k] <= '0;
    end else begin
      pipe[0][0] <= 16'(ref_sum(128'(in_a), 1, 8));
      pipe[1][0] <= 16'(ref_sum(128'(in_b), 3, 4));
      pipe[2][0] <= 16'(ref_sum(128'(in_c), 5, 16));
      pipe[3][0] <= 16'(ref_sum(in_d, 16, 8));
      for (int s = 0; s < 4; s++)
        for (int k = 1; k < 4; k++) pipe[s][k] <= pipe[s][k-1];
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: out=%0h expected=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] vin;
    logic [7:0]  exp;
  } vec_t;

  vec_t tab [15];

  initial begin
    // Walking single nonzero lane k carrying value k+1.
    for (int k = 0; k < 8; k++) begin
      tab[k].vin = 64'(k + 1) << (8 * k);
      tab[k].exp = 8'(k + 1);
    end
    tab[8]  = '{64'h0706050403020100, 8'h1C};
    tab[9]  = '{64'h0001020304050606, 8'h1B};
    tab[10] = '{64'hFFFFFFFFFFFFFFFF, 8'hF8};
    tab[11] = '{64'h0000008000000080, 8'h00};
    tab[12] = '{64'h0102040810204080, 8'hFF};
    tab[13] = '{64'h1020304050607080, 8'h40};
    tab[14] = '{64'h0000000000000000, 8'h00};

    rst = 1'b1; in0 = '0; in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    @(negedge clk);
    tick();
    check("reset out0",  32'(out0),  32'h0);
    check("reset out_a", 32'(out_a), 32'h0);
    check("reset out_b", 32'(out_b), 32'h0);
    check("reset out_c", 32'(out_c), 32'h0);
    check("reset out_d", 32'(out_d), 32'h0);

    // Basic sum: zero until the third edge after sampling.
    rst = 1'b0;
    in0 = 64'h0706050403020100;
    tick(); check("basic lat1", 32'(out0), 32'h0);
    tick(); check("basic lat2", 32'(out0), 32'h0);
    tick(); check("basic lat3", 32'(out0), 32'h1C);

    // Back-to-back vectors, then hold.
    in0 = 64'h0001020304050606; tick();
    in0 = 64'h0706050403020100; tick();
    check("b2b hold0", 32'(out0), 32'h1C);
    tick(); check("b2b v2",  32'(out0), 32'h1B);
    tick(); check("b2b v3",  32'(out0), 32'h1C);
    tick(); check("b2b hold", 32'(out0), 32'h1C);

    // Table vectors streamed one per clock; result of entry i seen two ticks later.
    for (int i = 0; i < 17; i++) begin
      in0 = (i < 15) ? tab[i].vin : 64'h0;
      tick();
      if (i >= 2) check($sformatf("tab[%0d]", i - 2), 32'(out0), 32'(tab[i-2].exp));
    end

    // Reset mid-stream flushes in-flight sums.
    in0 = 64'hFFFFFFFFFFFFFFFF; tick();
    in0 = 64'h0706050403020100; tick();
    in0 = 64'h0102040810204080; tick();
    rst = 1'b1; in0 = 64'h1111111111111111;
    tick(); check("midrst out", 32'(out0), 32'h0);
    rst = 1'b0; in0 = 64'h1020304050607080;
    tick(); check("postrst 1", 32'(out0), 32'h0);
    tick(); check("postrst 2", 32'(out0), 32'h0);
    tick(); check("postrst 3", 32'(out0), 32'h40);

    // Out of reset with zero input stays zero.
    rst = 1'b1; in0 = '0; tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("zero in", 32'(out0), 32'h0);
    end

    // Parameter sweep: all-ones first, then random vectors every clock.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < 2) begin
        in_a = '1; in_b = '1; in_c = '1; in_d = '1;
      end else begin
        in_a = 8'($urandom);
        in_b = 12'($urandom);
        in_c = {16'($urandom), $urandom, $urandom};
        in_d = {$urandom, $urandom, $urandom, $urandom};
      end
      in0 = {$urandom, $urandom};
      tick();
      check($sformatf("sweep n1w8 c%0d", c),  32'(out_a), 32'(pipe[0][0][7:0]));
      check($sformatf("sweep n3w4 c%0d", c),  32'(out_b), 32'(pipe[1][1][3:0]));
      check($sformatf("sweep n5w16 c%0d", c), 32'(out_c), 32'(pipe[2][2]));
      check($sformatf("sweep n16w8 c%0d", c), 32'(out_d), 32'(pipe[3][3][7:0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
